alu_issue: RTL and testbench
============================

// Module: alu_issue
// PURPOSE
// - Issue side of the ALU: decodes RISC-V R-type, I-type and branch instructions into the 4-bit ALU ctrl code.
// - Drives alu ctrl/a/b from registers, captures alu c/zero, presents a writeback or branch result.
// - Sits between register read and writeback.
// - Valid/ready handshake on both sides; one instruction in flight.
// PARAMETERS
// - DATA_WIDTH  32  operand/result width; also the PC width
// - CTRL_BITS   4   ALU ctrl width
// PORTS
// - clk             in   1           single clock, rising edge
// - rst             in   1           asynchronous, active-high reset
// - in_valid        in   1           instruction + operands valid
// - in_ready        out  1           issue accepts (in_valid & in_ready = accept)
// - inst            in   32          RISC-V instruction word
// - rs1_data        in   DATA_WIDTH  rs1 value
// - rs2_data        in   DATA_WIDTH  rs2 value
// - pc              in   DATA_WIDTH  instruction address
// - alu_ctrl        out  CTRL_BITS   to ALU ctrl
// - alu_a, alu_b    out  DATA_WIDTH  to ALU operands
// - alu_c           in   DATA_WIDTH  ALU result
// - alu_zero        in   1           ALU zero flag
// - out_valid       out  1           result valid
// - out_ready       in   1           consumer accepts
// - out_rd          out  5           destination register
// - out_we          out  1           write rd with out_wdata
// - out_wdata       out  DATA_WIDTH  captured alu_c
// - out_taken       out  1           branch taken
// - out_target      out  DATA_WIDTH  pc + sign-extended B-immediate
// BEHAVIOUR
// - FSM IDLE -> EXEC -> HOLD.
//   - IDLE: in_ready=1; on accept, register decoded ctrl/a/b/rd/target, go to EXEC.
//   - EXEC: ALU settles; capture alu_c/alu_zero into output regs; go to HOLD.
//   - HOLD: out_valid=1 until out_ready.
//     - out_ready & in_valid: accept next instruction into EXEC, back-to-back, in_ready=1.
//     - out_ready & !in_valid: go to IDLE.
// - Latency: accept at edge N -> out_valid high after edge N+2.
// - Outputs hold stable while out_valid & !out_ready.
// - Decode. Opcode 0110011 (R-type) uses b=rs2; opcode 0010011 (I-type) uses b=sext(inst[31:20]).
//   - funct3 000 -> ADD (0010); SUB (0110) when R-type and funct7[5]=1
//   - funct3 010 -> SLT 0111; 011 -> SLTU 1111; 100 -> XOR 0001; 110 -> OR 0011; 111 -> AND 0000
//   - funct3 001/101 (shifts) are illegal.
// - Branch, opcode 1100011: b=rs2, out_we=0.
//   - BEQ -> SUB, taken=zero; BNE -> SUB, taken=!zero
//   - BLT -> SLT, taken=c[0]; BGE -> SGE 0101, taken=c[0]
//   - BLTU/BGEU are illegal.
// - out_target: own adder; 32-bit modulo wrap; don't-care for non-branches.
// - out_we=1 for R/I with rd!=0; out_we forced 0 when rd==0.
// - Illegal or unknown opcode: alu_ctrl=AND, out_we=0, out_taken=0; still produces a result beat.
// - Reset values: state IDLE; in_ready=1; out_valid, out_we, out_taken=0; alu_ctrl=0; alu_a, alu_b, out_wdata, out_target, out_rd=0.
// - Reset mid-operation aborts the in-flight instruction; no out_valid for it.
// CONFIGURATION
// - ALU_ISSUE_TRAP_EN defined: extra output port `out_illegal` (1 bit).
//   - Set with out_valid for an illegal decode; reset 0.
// - ALU_ISSUE_TRAP_EN undefined: no port; illegal instructions silently retire as NOPs.
// STRUCTURE
// - alu_pkg holds:
//   - ALU ctrl localparams: AND, OR, XOR, ADD, SUB, SLT, SLTU, SGE, NOR
//   - opcode constants: OP_R, OP_I, OP_BR
//   - funct3 constants
//   - FSM state encoding
// - Sub-module alu_issue_dec: combinational decode inst -> ctrl, use_imm, imm, rd, is_branch, br_kind, illegal.
// - Top holds FSM, operand/output registers and target adder.
// TESTING
// - ADD x3,x1,x2 with rs1=75, rs2=25 -> alu_ctrl=0010; out_wdata=100, out_we=1, out_rd=3; out_valid 2 cycles after accept.
// - SUB with rs1=1, rs2=1 -> alu_ctrl=0110, out_wdata=0; with ALU attached alu_zero=1.
// - BEQ rs1=rs2=5, imm=+16, pc=0x100 -> out_taken=1, out_target=0x110, out_we=0.
// - BNE same operands -> out_taken=0.
// - ADDI x0,x1,7 -> out_we=0; ADDI imm=0xFFF with rs1=1 -> out_wdata=0.
// - out_ready held low 5 cycles -> outputs stable, in_ready=0 throughout.
//   - Then out_ready & in_valid together -> next instruction accepted that cycle.
// - SLL (funct3 001) -> out_we=0; out_illegal=1 under ALU_ISSUE_TRAP_EN.
// - rst pulsed during EXEC -> out_valid stays 0, in_ready=1 next cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU issue definitions: ALU control codes, RISC-V opcode/funct3 fields,
// FSM state encoding and branch kinds.
package alu_pkg;

  localparam int CTRL_W = 4;

  localparam logic [CTRL_W-1:0] ALU_AND  = 4'b0000;
  localparam logic [CTRL_W-1:0] ALU_XOR  = 4'b0001;
  localparam logic [CTRL_W-1:0] ALU_ADD  = 4'b0010;
  localparam logic [CTRL_W-1:0] ALU_OR   = 4'b0011;
  localparam logic [CTRL_W-1:0] ALU_SGE  = 4'b0101;
  localparam logic [CTRL_W-1:0] ALU_SUB  = 4'b0110;
  localparam logic [CTRL_W-1:0] ALU_SLT  = 4'b0111;
  localparam logic [CTRL_W-1:0] ALU_NOR  = 4'b1100;
  localparam logic [CTRL_W-1:0] ALU_SLTU = 4'b1111;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_HOLD} state_t;

  typedef enum logic [1:0] {BR_EQ, BR_NE, BR_LT, BR_GE} br_kind_t;

endpackage

// File: rtl/alu_issue_if.sv
// Issue-side handshake bundle: instruction/operand input and writeback/branch output.
// out_illegal exists only when ALU_ISSUE_TRAP_EN is defined.
interface alu_issue_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           inst;
  logic [DATA_WIDTH-1:0] rs1_data;
  logic [DATA_WIDTH-1:0] rs2_data;
  logic [DATA_WIDTH-1:0] pc;

  logic                  out_valid;
  logic                  out_ready;
  logic [4:0]            out_rd;
  logic                  out_we;
  logic [DATA_WIDTH-1:0] out_wdata;
  logic                  out_taken;
  logic [DATA_WIDTH-1:0] out_target;
`ifdef ALU_ISSUE_TRAP_EN
  logic                  out_illegal;

  modport master (
    output in_valid, inst, rs1_data, rs2_data, pc, out_ready,
    input  in_ready, out_valid, out_rd, out_we, out_wdata, out_taken, out_target, out_illegal
  );

  modport slave (
    input  in_valid, inst, rs1_data, rs2_data, pc, out_ready,
    output in_ready, out_valid, out_rd, out_we, out_wdata, out_taken, out_target, out_illegal
  );
`else
  modport master (
    output in_valid, inst, rs1_data, rs2_data, pc, out_ready,
    input  in_ready, out_valid, out_rd, out_we, out_wdata, out_taken, out_target
  );

  modport slave (
    input  in_valid, inst, rs1_data, rs2_data, pc, out_ready,
    output in_ready, out_valid, out_rd, out_we, out_wdata, out_taken, out_target
  );
`endif

endinterface

// File: rtl/alu_issue_dec.sv
// Combinational RISC-V decode of R-type, I-type and branch instructions into
// ALU control, operand-B select, immediate, destination and branch kind.
module alu_issue_dec
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [31:0]           inst,
  output logic [CTRL_W-1:0]     ctrl,
  output logic                  use_imm,
  output logic [DATA_WIDTH-1:0] imm,
  output logic [4:0]            rd,
  output logic                  is_branch,
  output br_kind_t              br_kind,
  output logic                  illegal
);

  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [DATA_WIDTH-1:0] i_imm;
  logic [DATA_WIDTH-1:0] b_imm;
  logic                  unused_rs1;

  assign opcode     = inst[6:0];
  assign funct3     = inst[14:12];
  assign rd         = inst[11:7];
  assign unused_rs1 = ^inst[19:15];

  assign i_imm = {{(DATA_WIDTH-12){inst[31]}}, inst[31:20]};
  assign b_imm = {{(DATA_WIDTH-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  // The same immediate feeds operand B for I-type and the target adder for branches.
  assign imm   = (opcode == OP_I) ? i_imm : b_imm;

  always_comb begin
    ctrl      = ALU_AND;
    use_imm   = 1'b0;
    is_branch = 1'b0;
    br_kind   = BR_EQ;
    illegal   = 1'b0;
    case (opcode)
      OP_R, OP_I: begin
        use_imm = (opcode == OP_I);
        case (funct3)
          F3_ADD:  ctrl = (opcode == OP_R && inst[30]) ? ALU_SUB : ALU_ADD;
          F3_SLT:  ctrl = ALU_SLT;
          F3_SLTU: ctrl = ALU_SLTU;
          F3_XOR:  ctrl = ALU_XOR;
          F3_OR:   ctrl = ALU_OR;
          F3_AND:  ctrl = ALU_AND;
          default: illegal = 1'b1;
        endcase
      end
      OP_BR: begin
        case (funct3)
          F3_BEQ: begin ctrl = ALU_SUB; br_kind = BR_EQ; is_branch = 1'b1; end
          F3_BNE: begin ctrl = ALU_SUB; br_kind = BR_NE; is_branch = 1'b1; end
          F3_BLT: begin ctrl = ALU_SLT; br_kind = BR_LT; is_branch = 1'b1; end
          F3_BGE: begin ctrl = ALU_SGE; br_kind = BR_GE; is_branch = 1'b1; end
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: registers decoded ctrl/operands, captures the ALU result and
// presents a writeback or branch beat. Optional out_illegal under ALU_ISSUE_TRAP_EN.
module alu_issue
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_BITS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_issue_if.slave            bus,
  output logic [CTRL_BITS-1:0]  alu_ctrl,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  input  logic [DATA_WIDTH-1:0] alu_c,
  input  logic                  alu_zero
);

  state_t                state;
  logic                  settled;
  logic                  in_ready;
  logic                  accept;
  logic                  taken_now;

  logic [CTRL_W-1:0]     dec_ctrl;
  logic                  dec_use_imm;
  logic [DATA_WIDTH-1:0] dec_imm;
  logic [4:0]            dec_rd;
  logic                  dec_is_branch;
  br_kind_t              dec_br_kind;
  logic                  dec_illegal;

  logic [4:0]            rd_q;
  logic                  we_q;
  logic                  branch_q;
  br_kind_t              kind_q;
  logic [DATA_WIDTH-1:0] target_q;

  logic                  out_valid_q;
  logic [4:0]            out_rd_q;
  logic                  out_we_q;
  logic [DATA_WIDTH-1:0] out_wdata_q;
  logic                  out_taken_q;
  logic [DATA_WIDTH-1:0] out_target_q;
`ifdef ALU_ISSUE_TRAP_EN
  logic                  illegal_q;
  logic                  out_illegal_q;
`endif

  alu_issue_dec #(.DATA_WIDTH(DATA_WIDTH)) u_dec (
    .inst      (bus.inst),
    .ctrl      (dec_ctrl),
    .use_imm   (dec_use_imm),
    .imm       (dec_imm),
    .rd        (dec_rd),
    .is_branch (dec_is_branch),
    .br_kind   (dec_br_kind),
    .illegal   (dec_illegal)
  );

  // A draining HOLD beat frees the stage, so the next instruction may enter the same cycle.
  assign in_ready = (state == S_IDLE) || (state == S_HOLD && bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    taken_now = 1'b0;
    if (branch_q) begin
      case (kind_q)
        BR_EQ:   taken_now = alu_zero;
        BR_NE:   taken_now = !alu_zero;
        default: taken_now = alu_c[0];
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_ctrl <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      rd_q     <= '0;
      we_q     <= 1'b0;
      branch_q <= 1'b0;
      kind_q   <= BR_EQ;
      target_q <= '0;
`ifdef ALU_ISSUE_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else if (accept) begin
      alu_ctrl <= CTRL_BITS'(dec_ctrl);
      alu_a    <= bus.rs1_data;
      alu_b    <= dec_use_imm ? dec_imm : bus.rs2_data;
      rd_q     <= dec_rd;
      we_q     <= !dec_is_branch && !dec_illegal && (dec_rd != 5'd0);
      branch_q <= dec_is_branch;
      kind_q   <= dec_br_kind;
      target_q <= bus.pc + dec_imm;
`ifdef ALU_ISSUE_TRAP_EN
      illegal_q <= dec_illegal;
`endif
    end
  end

  // EXEC spends two cycles so a registered ALU result is also captured correctly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      settled      <= 1'b0;
      out_valid_q  <= 1'b0;
      out_rd_q     <= '0;
      out_we_q     <= 1'b0;
      out_wdata_q  <= '0;
      out_taken_q  <= 1'b0;
      out_target_q <= '0;
`ifdef ALU_ISSUE_TRAP_EN
      out_illegal_q <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) state <= S_EXEC;
        end
        S_EXEC: begin
          if (!settled) begin
            settled <= 1'b1;
          end else begin
            settled      <= 1'b0;
            out_valid_q  <= 1'b1;
            out_rd_q     <= rd_q;
            out_we_q     <= we_q;
            out_wdata_q  <= alu_c;
            out_taken_q  <= taken_now;
            out_target_q <= target_q;
`ifdef ALU_ISSUE_TRAP_EN
            out_illegal_q <= illegal_q;
`endif
            state        <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= bus.in_valid ? S_EXEC : S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_rd     = out_rd_q;
  assign bus.out_we     = out_we_q;
  assign bus.out_wdata  = out_wdata_q;
  assign bus.out_taken  = out_taken_q;
  assign bus.out_target = out_target_q;
`ifdef ALU_ISSUE_TRAP_EN
  assign bus.out_illegal = out_illegal_q;
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue with a behavioural ALU attached to its ALU ports.
module tb_alu_issue;

  localparam int DW = 32;

  localparam logic [3:0] C_AND  = 4'b0000;
  localparam logic [3:0] C_OR   = 4'b0011;
  localparam logic [3:0] C_XOR  = 4'b0001;
  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_SLT  = 4'b0111;
  localparam logic [3:0] C_SLTU = 4'b1111;
  localparam logic [3:0] C_SGE  = 4'b0101;

  typedef struct {
    logic [3:0]  ctrl;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic        chk_wdata;
    logic        taken;
    logic [31:0] target;
    logic        chk_target;
    logic        illegal;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    alu_ctrl;
  logic [DW-1:0] alu_a, alu_b, alu_c;
  logic          alu_zero;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  alu_issue_if #(.DATA_WIDTH(DW)) bus ();

  alu_issue #(.DATA_WIDTH(DW), .CTRL_BITS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .alu_ctrl (alu_ctrl),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_c    (alu_c),
    .alu_zero (alu_zero)
  );

  // Behavioural ALU
  always_comb begin
    case (alu_ctrl)
      C_AND:   alu_c = alu_a & alu_b;
      C_OR:    alu_c = alu_a | alu_b;
      C_XOR:   alu_c = alu_a ^ alu_b;
      C_ADD:   alu_c = alu_a + alu_b;
      C_SUB:   alu_c = alu_a - alu_b;
      C_SLT:   alu_c = {31'd0, $signed(alu_a) < $signed(alu_b)};
      C_SLTU:  alu_c = {31'd0, alu_a < alu_b};
      C_SGE:   alu_c = {31'd0, $signed(alu_a) >= $signed(alu_b)};
      default: alu_c = ~(alu_a | alu_b);
    endcase
    alu_zero = (alu_c == 32'd0);
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] mkR(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] mkI(input logic [11:0] imm, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] mkB(input int off, input logic [4:0] rs2, input logic [4:0] rs1,
                                      input logic [2:0] f3);
    logic [12:0] b;
    b = off[12:0];
    return {b[12], b[10:5], rs2, rs1, f3, b[4:1], b[11], 7'b1100011};
  endfunction

  function automatic exp_t refModel(input logic [31:0] inst, input logic [31:0] a, input logic [31:0] b2,
                                    input logic [31:0] pc, input int off);
    exp_t        e;
    logic [31:0] bop;
    logic [31:0] res;
    logic [6:0]  opc;
    logic [2:0]  f3;
    opc = inst[6:0];
    f3  = inst[14:12];
    e.ctrl = C_AND; e.we = 1'b0; e.rd = inst[11:7]; e.wdata = '0; e.chk_wdata = 1'b0;
    e.taken = 1'b0; e.target = '0; e.chk_target = 1'b0; e.illegal = 1'b0;
    res = '0;
    if (opc == 7'b0110011 || opc == 7'b0010011) begin
      bop = (opc == 7'b0110011) ? b2 : {{20{inst[31]}}, inst[31:20]};
      case (f3)
        3'b000: if (opc == 7'b0110011 && inst[30]) begin e.ctrl = C_SUB; res = a - bop; end
                else begin e.ctrl = C_ADD; res = a + bop; end
        3'b010: begin e.ctrl = C_SLT;  res = {31'd0, $signed(a) < $signed(bop)}; end
        3'b011: begin e.ctrl = C_SLTU; res = {31'd0, a < bop}; end
        3'b100: begin e.ctrl = C_XOR;  res = a ^ bop; end
        3'b110: begin e.ctrl = C_OR;   res = a | bop; end
        3'b111: begin e.ctrl = C_AND;  res = a & bop; end
        default: e.illegal = 1'b1;
      endcase
      if (!e.illegal) begin
        e.we = (inst[11:7] != 5'd0);
        e.wdata = res;
        e.chk_wdata = 1'b1;
      end
    end else if (opc == 7'b1100011) begin
      case (f3)
        3'b000: begin e.ctrl = C_SUB; e.taken = (a == b2); end
        3'b001: begin e.ctrl = C_SUB; e.taken = (a != b2); end
        3'b100: begin e.ctrl = C_SLT; e.taken = ($signed(a) < $signed(b2)); end
        3'b101: begin e.ctrl = C_SGE; e.taken = ($signed(a) >= $signed(b2)); end
        default: e.illegal = 1'b1;
      endcase
      if (!e.illegal) begin
        e.target = pc + off;
        e.chk_target = 1'b1;
      end
    end else begin
      e.illegal = 1'b1;
    end
    if (e.illegal) e.ctrl = C_AND;
    return e;
  endfunction

  // Output monitor: every completed beat is compared against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_beat", bus.out_valid, 1'b0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("alu_ctrl", alu_ctrl, mon_e.ctrl);
        checkOutput("out_we", bus.out_we, mon_e.we);
        checkOutput("out_taken", bus.out_taken, mon_e.taken);
        if (mon_e.we) checkOutput("out_rd", bus.out_rd, mon_e.rd);
        if (mon_e.chk_wdata) checkOutput("out_wdata", bus.out_wdata, mon_e.wdata);
        if (mon_e.chk_target) checkOutput("out_target", bus.out_target, mon_e.target);
`ifdef ALU_ISSUE_TRAP_EN
        checkOutput("out_illegal", bus.out_illegal, mon_e.illegal);
`endif
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] inst, input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic [31:0] pc, input int off, input bit track);
    bit ok;
    if (track) sb.push_back(refModel(inst, rs1, rs2, pc, off));
    bus.inst = inst; bus.rs1_data = rs1; bus.rs2_data = rs2; bus.pc = pc;
    bus.in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        @(posedge clk);
        #1;
      end
    end
    if (!ok) checkOutput("accept_timeout", bus.in_ready, 1'b1);
    bus.in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) begin
      @(posedge clk);
      #2;
    end
    checkOutput("drain", sb.size(), 0);
  endtask

  task automatic runOne(input logic [31:0] inst, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] pc, input int off);
    applyStimulus(inst, rs1, rs2, pc, off, 1'b1);
    waitDrain();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit got;
    logic [2:0] f3s;
    logic [6:0] f7s;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.inst = '0; bus.rs1_data = '0; bus.rs2_data = '0; bus.pc = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_in_ready", bus.in_ready, 1'b1);
    checkOutput("rst_out_valid", bus.out_valid, 1'b0);
    checkOutput("rst_out_we", bus.out_we, 1'b0);
    checkOutput("rst_out_taken", bus.out_taken, 1'b0);
    checkOutput("rst_alu_ctrl", alu_ctrl, 4'd0);
    checkOutput("rst_alu_a", alu_a, 32'd0);
    checkOutput("rst_alu_b", alu_b, 32'd0);
    checkOutput("rst_out_wdata", bus.out_wdata, 32'd0);
    checkOutput("rst_out_target", bus.out_target, 32'd0);
    checkOutput("rst_out_rd", bus.out_rd, 5'd0);
    @(posedge clk); #1;

    // ADD x3,x1,x2 with latency check
    applyStimulus(mkR(7'd0, 5'd2, 5'd1, 3'b000, 5'd3), 32'd75, 32'd25, 32'd0, 0, 1'b1);
    @(negedge clk); checkOutput("lat_cycle1", bus.out_valid, 1'b0);
    @(negedge clk); checkOutput("lat_cycle2", bus.out_valid, 1'b0);
    @(negedge clk); checkOutput("lat_cycle3", bus.out_valid, 1'b1);
    waitDrain();

    runOne(mkR(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd4), 32'd1, 32'd1, 32'd0, 0);
    checkOutput("sub_zero", alu_zero, 1'b1);
    runOne(mkB(16, 5'd2, 5'd1, 3'b000), 32'd5, 32'd5, 32'h100, 16);
    runOne(mkB(16, 5'd2, 5'd1, 3'b001), 32'd5, 32'd5, 32'h100, 16);
    runOne(mkI(12'd7, 5'd1, 3'b000, 5'd0), 32'd5, 32'd0, 32'd0, 0);
    runOne(mkI(12'hFFF, 5'd1, 3'b000, 5'd5), 32'd1, 32'd0, 32'd0, 0);
    runOne(mkR(7'd0, 5'd2, 5'd1, 3'b010, 5'd6), 32'hFFFF_FFFD, 32'd2, 32'd0, 0);
    runOne(mkR(7'd0, 5'd2, 5'd1, 3'b011, 5'd7), 32'hFFFF_FFFD, 32'd2, 32'd0, 0);
    runOne(mkI(12'h0F0, 5'd1, 3'b100, 5'd8), 32'h0000_00FF, 32'd0, 32'd0, 0);
    runOne(mkR(7'd0, 5'd2, 5'd1, 3'b110, 5'd9), 32'h0F00_00F0, 32'h00F0_0F00, 32'd0, 0);
    runOne(mkI(12'h800, 5'd1, 3'b111, 5'd10), 32'hFFFF_F0FF, 32'd0, 32'd0, 0);
    runOne(mkB(-8, 5'd2, 5'd1, 3'b100), 32'hFFFF_FFFF, 32'd1, 32'h0000_0004, -8);
    runOne(mkB(32, 5'd2, 5'd1, 3'b101), 32'd2, 32'd3, 32'h0000_0200, 32);
    runOne(mkB(-8, 5'd2, 5'd1, 3'b101), 32'd3, 32'd3, 32'h0000_0004, -8);
    runOne(mkR(7'd0, 5'd2, 5'd1, 3'b001, 5'd11), 32'd3, 32'd1, 32'd0, 0);
    runOne(32'hFFFF_FFFF, 32'd3, 32'd1, 32'd0, 0);
    runOne(mkB(8, 5'd2, 5'd1, 3'b110), 32'd1, 32'd2, 32'd0, 8);

    for (int k = 0; k < 16; k++) begin
      case ($urandom_range(0, 5))
        0: f3s = 3'b000;
        1: f3s = 3'b010;
        2: f3s = 3'b011;
        3: f3s = 3'b100;
        4: f3s = 3'b110;
        default: f3s = 3'b111;
      endcase
      f7s = ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'd0;
      if (f3s != 3'b000) f7s = 7'd0;
      runOne(mkR(f7s, 5'd2, 5'd1, f3s, 5'($urandom_range(1, 31))), $urandom, $urandom, 32'd0, 0);
    end

    // Back-pressure, then back-to-back accept on release
    bus.out_ready = 1'b0;
    applyStimulus(mkR(7'd0, 5'd2, 5'd1, 3'b000, 5'd7), 32'h10, 32'h20, 32'd0, 0, 1'b1);
    sb.push_back(refModel(mkI(12'd5, 5'd1, 3'b000, 5'd12), 32'd9, 32'd0, 32'd0, 0));
    bus.inst = mkI(12'd5, 5'd1, 3'b000, 5'd12); bus.rs1_data = 32'd9; bus.rs2_data = 32'd0;
    bus.in_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = bus.out_valid;
    end
    checkOutput("stall_reach_valid", bus.out_valid, 1'b1);
    repeat (5) begin
      @(negedge clk);
      checkOutput("stall_valid", bus.out_valid, 1'b1);
      checkOutput("stall_in_ready", bus.in_ready, 1'b0);
      checkOutput("stall_wdata", bus.out_wdata, 32'h30);
      checkOutput("stall_rd", bus.out_rd, 5'd7);
    end
    @(posedge clk); #1 bus.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("b2b_in_ready", bus.in_ready, 1'b1);
    @(posedge clk); #1 bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("b2b_exec_no_valid", bus.out_valid, 1'b0);
    waitDrain();

    // Reset during EXEC aborts the instruction
    applyStimulus(mkR(7'd0, 5'd2, 5'd1, 3'b000, 5'd3), 32'd1, 32'd2, 32'd0, 0, 1'b0);
    rst = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_in_ready", bus.in_ready, 1'b1);
    checkOutput("abort_valid", bus.out_valid, 1'b0);
    repeat (4) begin
      @(negedge clk);
      checkOutput("abort_valid_hold", bus.out_valid, 1'b0);
    end
    checkOutput("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
